// File: rtl/ram_pipe.sv
// Simple-dual-port RAM with byte-enable writes, tagged pipelined reads and a
// credit-gated output FIFO; an optional post-reset sweep zeroes the array.
module ram_pipe #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 64,
  parameter int USER_WIDTH    = 8,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int RD_LATENCY    = 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int INIT_ON_RESET = 1,
  parameter     RAM_STYLE     = "block"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  input  logic [STRB_WIDTH-1:0] s_write_strb,
  input  logic [ADDR_WIDTH-1:0] s_write_addr,
  input  logic                  s_write_valid,
  output logic                  s_write_ready,
  input  logic [ADDR_WIDTH-1:0] s_read_addr,
  input  logic [USER_WIDTH-1:0] s_read_user,
  input  logic                  s_read_valid,
  output logic                  s_read_ready,
  output logic [DATA_WIDTH-1:0] m_read_data,
  output logic [USER_WIDTH-1:0] m_read_user,
  output logic                  m_read_valid,
  input  logic                  m_read_ready,
  output logic                  init_done,
  output logic                  o_dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high; ready never depends combinationally on the matching valid.

  localparam int  DEPTH   = 1 << ADDR_WIDTH;
  localparam int  IW      = $clog2(FIFO_DEPTH);
  localparam int  PW      = IW + 1;
  localparam int  CW      = $clog2(FIFO_DEPTH + 1);
  localparam bit  INIT_EN = (INIT_ON_RESET != 0);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_init_addr;
  logic                    r_init_done;

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                    w_run;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic                    w_init_we;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_waddr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [STRB_WIDTH-1:0]   w_wstrb;

  logic                    r_s1_vld;
  logic [DATA_WIDTH-1:0]   r_s1_raw;
  logic [DATA_WIDTH-1:0]   r_s1_wdata;
  logic [STRB_WIDTH-1:0]   r_s1_wstrb;
  logic [USER_WIDTH-1:0]   r_s1_user;
  logic [DATA_WIDTH-1:0]   w_s1_data;

  logic                    w_push;
  logic [DATA_WIDTH-1:0]   w_push_data;
  logic [USER_WIDTH-1:0]   w_push_user;
  logic                    w_pop;

  logic [DATA_WIDTH-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [USER_WIDTH-1:0]   r_fifo_user [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (!INIT_EN) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
            if (r_init_addr == {ADDR_WIDTH{1'b1}}) begin
              r_state     <= ST_RUN;
              r_init_done <= 1'b1;
            end
          end
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign w_run         = (r_state == ST_RUN);
  assign s_write_ready = w_run;
  assign s_read_ready  = w_run && (r_credit < CW'(FIFO_DEPTH));
  assign init_done     = r_init_done;
  assign o_dbg_state   = r_state;

  assign w_wr_acc  = s_write_valid & s_write_ready;
  assign w_rd_acc  = s_read_valid & s_read_ready;
  assign w_init_we = INIT_EN && (r_state == ST_INIT) && !rst;
  assign w_we      = w_wr_acc | w_init_we;
  assign w_waddr   = w_init_we ? r_init_addr : s_write_addr;
  assign w_wdata   = w_init_we ? '0 : s_write_data;
  assign w_wstrb   = w_init_we ? '1 : s_write_strb;

  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (w_we && w_wstrb[b]) r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  // The RAM read returns the pre-write word; a same-address write accepted in the
  // same cycle is captured alongside and merged in byte-wise at the next stage.
  always_ff @(posedge clk) begin
    r_s1_raw   <= r_mem[s_read_addr];
    r_s1_wdata <= s_write_data;
    r_s1_wstrb <= (w_wr_acc && (s_write_addr == s_read_addr)) ? s_write_strb : '0;
    r_s1_user  <= s_read_user;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_s1_vld <= 1'b0;
    else     r_s1_vld <= w_rd_acc;
  end

  for (genvar g = 0; g < STRB_WIDTH; g++) begin : g_merge
    assign w_s1_data[8*g +: 8] = r_s1_wstrb[g] ? r_s1_wdata[8*g +: 8] : r_s1_raw[8*g +: 8];
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  r_s2_vld;
    logic [DATA_WIDTH-1:0] r_s2_data;
    logic [USER_WIDTH-1:0] r_s2_user;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s2_vld  <= 1'b0;
        r_s2_data <= '0;
        r_s2_user <= '0;
      end else begin
        r_s2_vld  <= r_s1_vld;
        r_s2_data <= w_s1_data;
        r_s2_user <= r_s1_user;
      end
    end

    assign w_push      = r_s2_vld;
    assign w_push_data = r_s2_data;
    assign w_push_user = r_s2_user;
  end else begin : g_lat1
    assign w_push      = r_s1_vld;
    assign w_push_data = w_s1_data;
    assign w_push_user = r_s1_user;
  end

  assign m_read_valid = (r_wr_ptr != r_rd_ptr);
  assign m_read_data  = r_fifo_data[r_rd_ptr[IW-1:0]];
  assign m_read_user  = r_fifo_user[r_rd_ptr[IW-1:0]];
  assign w_pop        = m_read_valid & m_read_ready;

  // Credits cover every read between accept and pop, so a push never meets a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_credit <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_user[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr[IW-1:0]] <= w_push_data;
        r_fifo_user[r_wr_ptr[IW-1:0]] <= w_push_user;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_rd_acc, w_pop})
        2'b10:   r_credit <= r_credit + CW'(1);
        2'b01:   r_credit <= r_credit - CW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_pipe.sv
// Directed testbench for ram_pipe: drivers push expected responses into a queue,
// a negedge monitor pops and compares on every response handshake.
module tb_ram_pipe;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int UW = 8;
  localparam int SW = DW / 8;
  localparam int EW = UW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_write_data = '0;
  logic [SW-1:0] s_write_strb = '0;
  logic [AW-1:0] s_write_addr = '0;
  logic          s_write_valid = 1'b0;
  logic          s_write_ready;
  logic [AW-1:0] s_read_addr = '0;
  logic [UW-1:0] s_read_user = '0;
  logic          s_read_valid = 1'b0;
  logic          s_read_ready;
  logic [DW-1:0] m_read_data;
  logic [UW-1:0] m_read_user;
  logic          m_read_valid;
  logic          m_read_ready = 1'b1;
  logic          init_done;
  logic          dbg_state;

  ram_pipe #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .RD_LATENCY(2),
    .FIFO_DEPTH(4), .INIT_ON_RESET(1), .RAM_STYLE("block")
  ) u_dut (
    .clk(clk), .rst(rst),
    .s_write_data(s_write_data), .s_write_strb(s_write_strb),
    .s_write_addr(s_write_addr), .s_write_valid(s_write_valid),
    .s_write_ready(s_write_ready),
    .s_read_addr(s_read_addr), .s_read_user(s_read_user),
    .s_read_valid(s_read_valid), .s_read_ready(s_read_ready),
    .m_read_data(m_read_data), .m_read_user(m_read_user),
    .m_read_valid(m_read_valid), .m_read_ready(m_read_ready),
    .init_done(init_done), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int            tests_run = 0;
  int            tests_failed = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [16];
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_word = '0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: held-data check while stalled, scoreboard compare on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_read_valid) check("hold", {m_read_user, m_read_data}, prev_word);
      if (m_read_valid && m_read_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL stale: got user=%h data=%h, expected no response", m_read_user, m_read_data);
        end else begin
          check("resp", {m_read_user, m_read_data}, exp_q.pop_front());
        end
      end
      prev_stall = m_read_valid && !m_read_ready;
      prev_word  = {m_read_user, m_read_data};
    end
  end

  task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb);
    for (int b = 0; b < SW; b++) if (strb[b]) model_mem[addr][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb);
    int n = 0;
    s_write_addr = addr; s_write_data = data; s_write_strb = strb; s_write_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_write_ready) break;
      if (++n > 100) begin check("write_timeout", 1'b0, 1'b1); break; end
    end
    model_write(addr, data, strb);
    @(posedge clk); #1;
    s_write_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [UW-1:0] user, input logic [DW-1:0] exp);
    int n = 0;
    s_read_addr = addr; s_read_user = user; s_read_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_read_ready) break;
      if (++n > 100) begin check("read_timeout", 1'b0, 1'b1); break; end
    end
    exp_q.push_back({user, exp});
    @(posedge clk); #1;
    s_read_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_read_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", (n < 300), 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_init(output int cycles, output logic rdy_seen);
    cycles = 0; rdy_seen = 1'b0;
    while (!init_done && cycles < 100) begin
      if (s_write_ready || s_read_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  initial begin
    int   cyc;
    logic rdy_seen;
    int   acc;
    int   lat;
    int   consec;
    int   stalls;

    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wready", s_write_ready, 1'b0);
    check("rst_rready", s_read_ready, 1'b0);
    check("rst_mvalid", m_read_valid, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_mdata", {m_read_user, m_read_data}, '0);

    // T1: init sweep length, readies low during sweep, array reads back zero
    rst = 1'b0;
    wait_init(cyc, rdy_seen);
    check("t1_init_cycles", cyc, 16);
    check("t1_ready_during_init", rdy_seen, 1'b0);
    check("t1_wready_run", s_write_ready, 1'b1);
    for (int i = 0; i < 16; i++) do_read(AW'(i), UW'(i), 64'h0);
    wait_drain();

    // T2: byte-enable merge
    do_write(4'd3, 64'h1122334455667788, 8'hFF);
    do_write(4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_read(4'd3, 8'h21, 64'h11223344AAAAAAAA);
    do_write(4'd3, 64'h0, 8'h00);
    do_read(4'd3, 8'h22, 64'h11223344AAAAAAAA);
    wait_drain();

    // T3: same-cycle write and read to one address
    acc = 0;
    s_write_addr = 4'd5; s_write_data = 64'hDEAD; s_write_strb = 8'hFF; s_write_valid = 1'b1;
    s_read_addr  = 4'd5; s_read_user  = 8'h07;    s_read_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_write_ready && s_read_ready) break;
      if (++acc > 100) begin check("t3_timeout", 1'b0, 1'b1); break; end
    end
    exp_q.push_back({8'h07, 64'h000000000000DEAD});
    model_write(4'd5, 64'hDEAD, 8'hFF);
    @(posedge clk); #1;
    s_write_valid = 1'b0; s_read_valid = 1'b0;
    do_write(4'd5, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    wait_drain();

    // T4: credit limit under backpressure, in-order release, held data
    for (int i = 0; i < 4; i++) do_write(AW'(8 + i), 64'h0101010101010101 * (i + 1), 8'hFF);
    m_read_ready = 1'b0;
    acc = 0;
    s_read_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      s_read_addr = AW'(8 + acc);
      s_read_user = UW'(8'h40 + acc);
      @(negedge clk);
      if (s_read_ready) begin
        exp_q.push_back({s_read_user, model_mem[s_read_addr]});
        acc++;
      end
      @(posedge clk); #1;
    end
    s_read_valid = 1'b0;
    check("t4_accepts", acc, 4);
    check("t4_rready_full", s_read_ready, 1'b0);
    check("t4_mvalid_stalled", m_read_valid, 1'b1);
    m_read_ready = 1'b1;
    wait_drain();

    // T5: 100 back-to-back reads, latency and bubble-free streaming
    stalls = 0; lat = 0; consec = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          int n = 0;
          s_read_addr = AW'(i % 16); s_read_user = UW'(i); s_read_valid = 1'b1;
          forever begin
            @(negedge clk);
            if (s_read_ready) break;
            stalls++;
            if (++n > 100) break;
          end
          exp_q.push_back({UW'(i), model_mem[i % 16]});
          @(posedge clk); #1;
        end
        s_read_valid = 1'b0;
      end
      begin
        int n = 0;
        while (!(s_read_valid && s_read_ready) && n < 100) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        while (lat < 10) begin
          @(posedge clk); #1;
          lat++;
          if (m_read_valid) break;
        end
        forever begin
          @(negedge clk);
          if (!m_read_valid || consec >= 300) break;
          consec++;
        end
      end
    join
    check("t5_latency", lat, 2);
    check("t5_consecutive", consec, 100);
    check("t5_stalls", stalls, 0);
    wait_drain();

    // T6: async reset with reads in flight
    acc = 0;
    s_read_valid = 1'b1;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      s_read_addr = AW'(8 + acc); s_read_user = UW'(8'h60 + acc);
      @(negedge clk);
      if (s_read_ready) begin
        exp_q.push_back({s_read_user, model_mem[s_read_addr]});
        acc++;
      end
      @(posedge clk); #1;
    end
    s_read_valid = 1'b0;
    check("t6_pre_valid", m_read_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t6_async_mvalid", m_read_valid, 1'b0);
    check("t6_async_rready", s_read_ready, 1'b0);
    check("t6_async_init_done", init_done, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_init(cyc, rdy_seen);
    check("t6_init_cycles", cyc, 16);
    repeat (12) @(posedge clk);
    #1;
    do_read(4'd9, 8'h77, 64'h0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
